// File: rtl/vga_fb_arbiter_if.sv
// Writer-side handshake bundle for the framebuffer arbiter.
// master = pixel writer, slave = arbiter.
interface vga_fb_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 24
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          swap_req;
  logic          swap_ack;

  modport master (
    output wr_valid,
    input  wr_ready,
    output wr_addr,
    output wr_data,
    output swap_req,
    input  swap_ack
  );

  modport slave (
    input  wr_valid,
    output wr_ready,
    input  wr_addr,
    input  wr_data,
    input  swap_req,
    output swap_ack
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Double-buffered framebuffer arbiter: display reads always win,
// writer fills the back bank, bank swap waits for vsync fall.
module vga_fb_arbiter #(
  parameter int AW        = 19,
  parameter int DW        = 24,
  parameter int STALL_MAX = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          disp_en,
  input  logic [AW-1:0] disp_addr,
  input  logic          vs,
  output logic [DW-1:0] disp_data,
  output logic          disp_vld,
  vga_fb_arbiter_if.slave wr,
  output logic          front_bank,
  output logic          wr_starve,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW:0]   mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(STALL_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STALL_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(STALL_MAX - 1);

  localparam logic [0:0] RUN       = 1'b0;
  localparam logic [0:0] SWAP_PEND = 1'b1;

  logic [0:0]    state;
  logic          vs_q;
  logic          rd_p;
  logic          swap_ack_q;
  logic [CW-1:0] stall_cnt;
  logic          vs_fall;
  logic          wr_fire;
  logic          stalling;
  logic          starve_set;
  logic          disp_go;

  assign vs_fall = vs_q & ~vs;
  assign disp_go = rst_n & disp_en;

  assign wr.wr_ready = rst_n & wr.wr_valid & ~disp_en
                     & (state == RUN);
  assign wr_fire  = wr.wr_valid & wr.wr_ready;
  assign stalling = (state == RUN) & wr.wr_valid
                  & ~wr.wr_ready;
  assign starve_set = stalling & (stall_cnt >= CNT_LAST);
  assign wr.swap_ack = swap_ack_q;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {front_bank, disp_addr};
    mem_wdata = wr.wr_data;
    unique case (1'b1)
      disp_go: begin
        mem_en = 1'b1;
      end
      wr_fire: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {~front_bank, wr.wr_addr};
      end
      default: ;
    endcase
  end

  // Swap only at a vsync falling edge so a frame is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      front_bank <= 1'b0;
      swap_ack_q <= 1'b0;
      vs_q       <= 1'b1;
    end else begin
      vs_q       <= vs;
      swap_ack_q <= 1'b0;
      unique case (state)
        RUN: begin
          if (wr.swap_req)
            state <= SWAP_PEND;
        end
        SWAP_PEND: begin
          if (vs_fall) begin
            state      <= RUN;
            front_bank <= ~front_bank;
            swap_ack_q <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_p      <= 1'b0;
      disp_vld  <= 1'b0;
      disp_data <= '0;
    end else begin
      rd_p     <= disp_en;
      disp_vld <= rd_p;
      if (rd_p)
        disp_data <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      wr_starve <= 1'b0;
    end else begin
      if (wr_fire)
        stall_cnt <= '0;
      else if (stalling && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + 1'b1;
      if (starve_set)
        wr_starve <= 1'b1;
      else if (vs_fall)
        wr_starve <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a small
// registered-read RAM model behind the memory port.
module tb_vga_fb_arbiter;
  localparam int AW = 19;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_en;
  logic [AW-1:0] disp_addr;
  logic          vs;
  logic [DW-1:0] disp_data;
  logic          disp_vld;
  logic          front_bank;
  logic          wr_starve;
  logic          mem_en;
  logic          mem_we;
  logic [AW:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  vga_fb_arbiter_if #(.AW(AW), .DW(DW)) wr_if ();

  vga_fb_arbiter #(
    .AW(AW), .DW(DW), .STALL_MAX(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_en    (disp_en),
    .disp_addr  (disp_addr),
    .vs         (vs),
    .disp_data  (disp_data),
    .disp_vld   (disp_vld),
    .wr         (wr_if.slave),
    .front_bank (front_bank),
    .wr_starve  (wr_starve),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:1023];
  logic [9:0]    ram_idx;
  assign ram_idx = {mem_addr[AW], mem_addr[8:0]};

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we)
        ram[ram_idx] <= mem_wdata;
      else
        mem_rdata <= ram[ram_idx];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    ram[10'd5] = 24'h123456;
    mem_rdata = '0;
    rst_n = 1'b0;
    disp_en = 1'b1;
    disp_addr = '0;
    vs = 1'b1;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr = '0;
    wr_if.wr_data = '0;
    wr_if.swap_req = 1'b0;
    #1;
    chk("rst_bank", 32'(front_bank), 0);
    chk("rst_vld", 32'(disp_vld), 0);
    chk("rst_data", 32'(disp_data), 0);
    chk("rst_starve", 32'(wr_starve), 0);
    chk("rst_ack", 32'(wr_if.swap_ack), 0);
    chk("rst_ready", 32'(wr_if.wr_ready), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    step();
    step();
    disp_en = 1'b0;
    wr_if.wr_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // read latency
    disp_en = 1'b1;
    disp_addr = 19'd5;
    #1;
    chk("rd_mem_en", 32'(mem_en), 1);
    chk("rd_mem_we", 32'(mem_we), 0);
    chk("rd_addr", 32'(mem_addr), 32'h00005);
    step();
    disp_en = 1'b0;
    chk("rd_vld_n1", 32'(disp_vld), 0);
    step();
    chk("rd_vld_n2", 32'(disp_vld), 1);
    chk("rd_data_n2", 32'(disp_data), 32'h123456);
    step();
    chk("rd_vld_n3", 32'(disp_vld), 0);
    chk("rd_hold", 32'(disp_data), 32'h123456);

    // conflict + starvation
    disp_en = 1'b1;
    disp_addr = 19'd1;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr = 19'd7;
    wr_if.wr_data = 24'hABCDEF;
    for (int c = 1; c <= 10; c++) begin
      #1;
      chk($sformatf("cf_ready%0d", c), 32'(wr_if.wr_ready), 0);
      if (c == 8) chk("starve_c8", 32'(wr_starve), 0);
      if (c == 9) chk("starve_c9", 32'(wr_starve), 1);
      step();
    end
    disp_en = 1'b0;
    #1;
    chk("cf_ready", 32'(wr_if.wr_ready), 1);
    chk("cf_mem_en", 32'(mem_en), 1);
    chk("cf_mem_we", 32'(mem_we), 1);
    chk("cf_addr", 32'(mem_addr), 32'h80007);
    chk("cf_wdata", 32'(mem_wdata), 32'hABCDEF);
    step();
    wr_if.wr_valid = 1'b0;
    step();
    step();
    chk("starve_hold", 32'(wr_starve), 1);
    vs = 1'b0;
    step();
    chk("starve_clr", 32'(wr_starve), 0);
    chk("idle_mem_en", 32'(mem_en), 0);
    vs = 1'b1;
    step();

    // swap
    wr_if.swap_req = 1'b1;
    step();
    wr_if.swap_req = 1'b0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr = 19'd9;
    wr_if.wr_data = 24'h654321;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("sp_ready%0d", c), 32'(wr_if.wr_ready), 0);
      chk($sformatf("sp_bank%0d", c), 32'(front_bank), 0);
      step();
    end
    vs = 1'b0;
    #1;
    chk("sw_ack_pre", 32'(wr_if.swap_ack), 0);
    step();
    chk("sw_bank", 32'(front_bank), 1);
    chk("sw_ack", 32'(wr_if.swap_ack), 1);
    step();
    chk("sw_ack_once", 32'(wr_if.swap_ack), 0);
    chk("sw_ready", 32'(wr_if.wr_ready), 1);
    chk("sw_wr_addr", 32'(mem_addr), 32'h00009);
    step();
    wr_if.wr_valid = 1'b0;
    vs = 1'b1;
    disp_en = 1'b1;
    disp_addr = 19'd7;
    step();
    disp_en = 1'b0;
    step();
    chk("sw_rd_vld", 32'(disp_vld), 1);
    chk("sw_rd_data", 32'(disp_data), 32'hABCDEF);

    // coincidence of swap_req and vs fall
    step();
    vs = 1'b0;
    wr_if.swap_req = 1'b1;
    step();
    wr_if.swap_req = 1'b0;
    vs = 1'b1;
    chk("co_bank", 32'(front_bank), 1);
    chk("co_ack", 32'(wr_if.swap_ack), 0);
    wr_if.wr_valid = 1'b1;
    step();
    chk("co_pend_ready", 32'(wr_if.wr_ready), 0);
    chk("co_bank2", 32'(front_bank), 1);
    vs = 1'b0;
    step();
    chk("co_bank3", 32'(front_bank), 0);
    chk("co_ack3", 32'(wr_if.swap_ack), 1);
    wr_if.wr_valid = 1'b0;
    vs = 1'b1;
    step();

    // swap_req held across ack, then reset mid-swap
    wr_if.swap_req = 1'b1;
    step();
    vs = 1'b0;
    step();
    chk("rh_bank", 32'(front_bank), 1);
    chk("rh_ack", 32'(wr_if.swap_ack), 1);
    vs = 1'b1;
    step();
    wr_if.swap_req = 1'b0;
    wr_if.wr_valid = 1'b1;
    #1;
    chk("rh_repend", 32'(wr_if.wr_ready), 0);
    disp_en = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_bank", 32'(front_bank), 0);
    chk("rs_ack", 32'(wr_if.swap_ack), 0);
    chk("rs_ready", 32'(wr_if.wr_ready), 0);
    chk("rs_mem_en", 32'(mem_en), 0);
    chk("rs_vld", 32'(disp_vld), 0);
    step();
    disp_en = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("rs_run_ready", 32'(wr_if.wr_ready), 1);
    step();
    wr_if.wr_valid = 1'b0;
    chk("rs_no_vld1", 32'(disp_vld), 0);
    step();
    chk("rs_no_vld2", 32'(disp_vld), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
